my_param_regfile: RTL and testbench

MY_PARAM_REGFILE -- requirements
Module: my_param_regfile

---
 rtl/my_param_regfile.sv | 146 ++++++++++++++
 tb/tb_my_param_regfile.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/my_param_regfile.sv
`default_nettype none
// ============================================================================
// Module      : my_param_regfile
// Description : Parameterised flip-flop register file with one write port and
//               two independent registered read ports (A and B).
//               - Optional hard-wired zero register (ZERO_REG).
//               - Optional write-to-read bypass on the same edge (BYPASS).
//               - Out-of-range writes are dropped; out-of-range reads return 0.
//               - Read data and valid appear one cycle after the request.
//
// Ports       :
//   clock             in   1           rising-edge clock
//   ctrl_reset        in   1           synchronous active-high reset
//   ctrl_writeEnable  in   1           write strobe
//   ctrl_writeReg     in   ADDR_WIDTH  write address
//   data_writeReg     in   DATA_WIDTH  write data
//   ctrl_readEnA/B    in   1           read request, port A / B
//   ctrl_readRegA/B   in   ADDR_WIDTH  read address, port A / B
//   data_readRegA/B   out  DATA_WIDTH  registered read data, port A / B
//   valid_readA/B     out  1           read data valid, port A / B
//
// Revision    : 1.0  initial release
// ============================================================================
module my_param_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic                  ctrl_readEnA,
    input  logic                  ctrl_readEnB,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    output logic                  valid_readA,
    output logic                  valid_readB
);

    // Array index width; never wider than ADDR_WIDTH since DEPTH <= 2**ADDR_WIDTH.
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // DEPTH resized to ADDR_WIDTH+1 bits so that DEPTH == 2**ADDR_WIDTH is
    // still representable in the range comparison.
    localparam logic [ADDR_WIDTH:0] c_DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < c_DEPTH_EXT);
    endfunction

    function automatic logic addr_is_zero_reg(input logic [ADDR_WIDTH-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  wr_qual;
    logic [c_IDX_W-1:0]    wr_idx;

    // A write qualifies when strobed, in range and not aimed at a hard-wired
    // zero register. Reset priority is applied in the storage process, so
    // this term deliberately excludes ctrl_reset.
    assign wr_qual = ctrl_writeEnable
                   && addr_in_range(ctrl_writeReg)
                   && !addr_is_zero_reg(ctrl_writeReg);
    assign wr_idx  = ctrl_writeReg[c_IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_qual) begin
            mem_q[wr_idx] <= data_writeReg;
        end
    end

    // ------------------------------------------------------------------------
    // Read ports: index 0 is port A, index 1 is port B
    // ------------------------------------------------------------------------
    logic [1:0]            rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr [2];

    assign rd_en[0]   = ctrl_readEnA;
    assign rd_en[1]   = ctrl_readEnB;
    assign rd_addr[0] = ctrl_readRegA;
    assign rd_addr[1] = ctrl_readRegB;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [DATA_WIDTH-1:0] rdata_d;
        logic [DATA_WIDTH-1:0] rdata_q;
        logic                  valid_d;
        logic                  valid_q;
        logic [c_IDX_W-1:0]    rd_idx;

        assign rd_idx = rd_addr[p][c_IDX_W-1:0];

        // Priority: out-of-range / zero register force zero, then bypass of a
        // same-edge qualifying write, then the stored entry. When idle the
        // data register simply holds.
        always_comb begin
            rdata_d = rdata_q;
            valid_d = 1'b0;
            if (rd_en[p]) begin
                valid_d = 1'b1;
                if (!addr_in_range(rd_addr[p]) || addr_is_zero_reg(rd_addr[p])) begin
                    rdata_d = '0;
                end else if ((BYPASS != 0) && wr_qual && (ctrl_writeReg == rd_addr[p])) begin
                    rdata_d = data_writeReg;
                end else begin
                    rdata_d = mem_q[rd_idx];
                end
            end
        end

        // Reset discards any request presented on the same edge.
        always_ff @(posedge clock) begin
            if (ctrl_reset) begin
                rdata_q <= '0;
                valid_q <= 1'b0;
            end else begin
                rdata_q <= rdata_d;
                valid_q <= valid_d;
            end
        end
    end

    assign data_readRegA = g_rd_port[0].rdata_q;
    assign valid_readA   = g_rd_port[0].valid_q;
    assign data_readRegB = g_rd_port[1].rdata_q;
    assign valid_readB   = g_rd_port[1].valid_q;

endmodule
`default_nettype wire

// File: tb/tb_my_param_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_my_param_regfile
// Description : Self-checking bench for my_param_regfile (DEPTH=20,
//               ZERO_REG=1, BYPASS=1). A reference model computes each read
//               result when the request is driven and pushes it to a per-port
//               queue; the entry is popped when the DUT presents valid data.
// Revision    : 1.0  initial release
// ============================================================================
module tb_my_param_regfile;

    localparam int DW  = 32;
    localparam int DEP = 20;
    localparam int AW  = 5;

    logic          clock = 1'b0;
    logic          ctrl_reset;
    logic          ctrl_writeEnable;
    logic [AW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg;
    logic          ctrl_readEnA;
    logic          ctrl_readEnB;
    logic [AW-1:0] ctrl_readRegA;
    logic [AW-1:0] ctrl_readRegB;
    logic [DW-1:0] data_readRegA;
    logic [DW-1:0] data_readRegB;
    logic          valid_readA;
    logic          valid_readB;

    always #5 clock = ~clock;

    my_param_regfile #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP),
        .ADDR_WIDTH (AW),
        .ZERO_REG   (1),
        .BYPASS     (1)
    ) u_dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readEnA     (ctrl_readEnA),
        .ctrl_readEnB     (ctrl_readEnB),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .valid_readA      (valid_readA),
        .valid_readB      (valid_readB)
    );

    // ------------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------------
    logic [DW-1:0] model [DEP];
    logic [DW-1:0] q_a [$];
    logic [DW-1:0] q_b [$];
    logic [DW-1:0] hold_a;
    logic [DW-1:0] hold_b;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic wr_ok(input logic we, input logic [AW-1:0] wa);
        return we && (int'(wa) < DEP) && (wa != '0);
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] addr, input logic we,
                                                 input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        if (int'(addr) >= DEP) return '0;
        if (addr == '0) return '0;
        if (wr_ok(we, wa) && (wa == addr)) return wd;
        return model[int'(addr)];
    endfunction

    // One clock cycle of stimulus followed by checking of both ports.
    task automatic cycle(input string tag, input logic rst,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic ena, input logic [AW-1:0] aa,
                         input logic enb, input logic [AW-1:0] ab);
        logic [DW-1:0] exp;
        ctrl_reset       = rst;
        ctrl_writeEnable = we;
        ctrl_writeReg    = wa;
        data_writeReg    = wd;
        ctrl_readEnA     = ena;
        ctrl_readRegA    = aa;
        ctrl_readEnB     = enb;
        ctrl_readRegB    = ab;
        if (!rst) begin
            if (ena) q_a.push_back(model_read(aa, we, wa, wd));
            if (enb) q_b.push_back(model_read(ab, we, wa, wd));
        end
        @(posedge clock);
        if (rst) begin
            for (int i = 0; i < DEP; i++) model[i] = '0;
        end else if (wr_ok(we, wa)) begin
            model[int'(wa)] = wd;
        end
        #1;
        check_eq({tag, ":validA"}, DW'(valid_readA), DW'(ena && !rst));
        check_eq({tag, ":validB"}, DW'(valid_readB), DW'(enb && !rst));
        if (rst) begin
            q_a.delete();
            q_b.delete();
            hold_a = '0;
            hold_b = '0;
            check_eq({tag, ":rstA"}, data_readRegA, '0);
            check_eq({tag, ":rstB"}, data_readRegB, '0);
        end else begin
            if (ena) begin
                exp    = q_a.pop_front();
                hold_a = exp;
                check_eq({tag, ":dataA"}, data_readRegA, exp);
            end else begin
                check_eq({tag, ":holdA"}, data_readRegA, hold_a);
            end
            if (enb) begin
                exp    = q_b.pop_front();
                hold_b = exp;
                check_eq({tag, ":dataB"}, data_readRegB, exp);
            end else begin
                check_eq({tag, ":holdB"}, data_readRegB, hold_b);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        hold_a = '0;
        hold_b = '0;
        for (int i = 0; i < DEP; i++) model[i] = '0;

        // Reset with a concurrent write and reads that must be ignored.
        cycle("rst0", 1, 1, 5'd3, 32'hAAAA_AAAA, 1, 5'd3, 1, 5'd3);
        cycle("rst1", 1, 0, 5'd0, 32'h0,         0, 5'd0, 0, 5'd0);

        // Post-reset reads: in-range and out-of-range both give zero.
        cycle("rd5_31", 0, 0, 5'd0, 32'h0, 1, 5'd5, 1, 5'd31);

        // Plain write then read one cycle later.
        cycle("wr7",   0, 1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0, 0, 5'd0);
        cycle("rd7",   0, 0, 5'd0, 32'h0,         1, 5'd7, 0, 5'd0);

        // Same-edge write/read of reg 9 on both ports exercises bypass.
        cycle("byp9",  0, 1, 5'd9, 32'h1234_5678, 1, 5'd9, 1, 5'd9);
        cycle("rd9",   0, 0, 5'd0, 32'h0,         1, 5'd9, 1, 5'd7);

        // Zero register ignores writes and never bypasses.
        cycle("wr0",   0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 0, 5'd0);
        cycle("rd0",   0, 0, 5'd0, 32'h0,         1, 5'd0, 1, 5'd0);

        // Out-of-range write must not alias onto any in-range entry.
        cycle("wr19",  0, 1, 5'd19, 32'h1313_1313, 0, 5'd0, 0, 5'd0);
        cycle("wr25",  0, 1, 5'd25, 32'hAAAA_5555, 1, 5'd25, 0, 5'd0);
        cycle("rd25",  0, 0, 5'd0,  32'h0,         1, 5'd25, 1, 5'd19);
        cycle("rd9_5", 0, 0, 5'd0,  32'h0,         1, 5'd9,  1, 5'd5);

        // Idle cycles: data holds, valid drops.
        cycle("idle",  0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 5'd0);
        cycle("idleB", 0, 0, 5'd0, 32'h0, 1, 5'd19, 0, 5'd0);

        // Fill 1..3, then reset with a concurrent write to 4 and read of 1;
        // a read is in flight when reset asserts.
        cycle("wr1",   0, 1, 5'd1, 32'h1111_1111, 0, 5'd0, 0, 5'd0);
        cycle("wr2",   0, 1, 5'd2, 32'h2222_2222, 0, 5'd0, 0, 5'd0);
        cycle("wr3",   0, 1, 5'd3, 32'h3333_3333, 1, 5'd1, 1, 5'd2);
        cycle("rstw4", 1, 1, 5'd4, 32'h4444_4444, 1, 5'd1, 0, 5'd0);
        cycle("rd1_2", 0, 0, 5'd0, 32'h0,         1, 5'd1, 1, 5'd2);
        cycle("rd3_4", 0, 0, 5'd0, 32'h0,         1, 5'd3, 1, 5'd4);

        // Randomised back-to-back traffic across the full address space.
        for (int n = 0; n < 400; n++) begin
            cycle("rand",
                  ($urandom_range(0, 49) == 0),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)),
                  $urandom,
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 3) != 0),
                  5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
